// File: rtl/fb_pkg.sv
// Shared types and screen constants for the framebuffer pixel sink.
package fb_pkg;
  localparam int SCREEN_W  = 160;
  localparam int SCREEN_H  = 120;
  localparam int FB_ADDR_W = 15;
  localparam int FB_PIXELS = 19200;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } fb_state_t;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [2:0] colour;
  } pixel_t;
endpackage

// File: rtl/plot_fifo.sv
// Synchronous pixel FIFO; occupancy flags come straight from the registered count.
module plot_fifo
  import fb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  pixel_t                        wdata,
  output pixel_t                        rdata,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  pixel_t mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
endmodule

// File: rtl/pixel_sink_fb.sv
// Pixel stream sink: clips, buffers and retires pixels into the framebuffer,
// and sweeps the whole screen with a fill colour on request.
module pixel_sink_fb #(
  parameter int FIFO_DEPTH = 4,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [2:0]  vga_colour,
  input  logic        plot,
  output logic        ready,
  input  logic        clear_start,
  input  logic [2:0]  clear_colour,
  output logic        clear_busy,
  output logic        clear_done,
  output logic [14:0] fb_addr,
  output logic [2:0]  fb_wdata,
  output logic        fb_we,
  input  logic        fb_wait,
  output logic [15:0] clipped_count,
  output logic        overflow
);
  import fb_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [FB_ADDR_W-1:0] LAST_ADDR = FB_ADDR_W'(FB_PIXELS - 1);

  fb_state_t              state_q, state_d;
  logic                   clear_pend_q, clear_pend_d;
  logic [FB_ADDR_W-1:0]   fb_addr_q, fb_addr_d;
  logic [2:0]             fb_wdata_q, fb_wdata_d;
  logic                   fb_we_q, fb_we_d;
  logic                   clear_done_q, clear_done_d;
  logic                   overflow_q, overflow_d;
  logic [15:0]            clipped_q, clipped_d;

  pixel_t                 push_pix, head_pix;
  logic                   push, pop, full, empty;
  logic [CNT_W-1:0]       fifo_count;
  logic                   on_screen, accept, out_free;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // y*160 + x as shifts; cannot overflow once the pixel has been clipped.
  function automatic logic [FB_ADDR_W-1:0] pix_addr(input logic [7:0] px, input logic [7:0] py);
    logic [FB_ADDR_W-1:0] yw, xw;
    yw = FB_ADDR_W'(py);
    xw = FB_ADDR_W'(px);
    return (yw << 7) + (yw << 5) + xw;
  endfunction

  plot_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (push_pix),
    .rdata (head_pix),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  assign ready = !full && (state_q != CLEAR);

  always_comb begin
    push_pix.x      = x;
    push_pix.y      = y;
    push_pix.colour = vga_colour;
    on_screen = (int'(x) < SCREEN_W) && (int'(y) < SCREEN_H);
    accept    = plot && ready;
    push      = accept && on_screen;
    out_free  = !fb_we_q || !fb_wait;
    pop       = 1'b0;

    state_d      = state_q;
    clear_pend_d = clear_pend_q;
    fb_addr_d    = fb_addr_q;
    fb_wdata_d   = fb_wdata_q;
    fb_we_d      = (fb_we_q && !fb_wait) ? 1'b0 : fb_we_q;
    clear_done_d = 1'b0;
    overflow_d   = overflow_q || (plot && !ready);
    clipped_d    = (accept && !on_screen) ? sat_inc(clipped_q) : clipped_q;

    unique case (state_q)
      IDLE: begin
        if (clear_start || clear_pend_q) begin
          state_d      = CLEAR;
          clear_pend_d = 1'b0;
          fb_we_d      = 1'b1;
          fb_addr_d    = '0;
          fb_wdata_d   = clear_colour;
        end else if (!empty) begin
          pop     = 1'b1;
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (clear_start) clear_pend_d = 1'b1;
        if (!empty && out_free) pop = 1'b1;
        else if (fifo_count == '0 && out_free) state_d = IDLE;
      end
      CLEAR: begin
        fb_we_d = 1'b1;
        if (!fb_wait) begin
          if (fb_addr_q == LAST_ADDR) begin
            fb_we_d      = 1'b0;
            clear_done_d = 1'b1;
            state_d      = IDLE;
          end else begin
            fb_addr_d = fb_addr_q + FB_ADDR_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      fb_we_d    = 1'b1;
      fb_addr_d  = pix_addr(head_pix.x, head_pix.y);
      fb_wdata_d = head_pix.colour;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      clear_pend_q <= 1'b0;
      fb_addr_q    <= '0;
      fb_wdata_q   <= '0;
      fb_we_q      <= 1'b0;
      clear_done_q <= 1'b0;
      overflow_q   <= 1'b0;
      clipped_q    <= '0;
    end else begin
      state_q      <= state_d;
      clear_pend_q <= clear_pend_d;
      fb_addr_q    <= fb_addr_d;
      fb_wdata_q   <= fb_wdata_d;
      fb_we_q      <= fb_we_d;
      clear_done_q <= clear_done_d;
      overflow_q   <= overflow_d;
      clipped_q    <= clipped_d;
    end
  end

  assign clear_busy    = (state_q == CLEAR);
  assign clear_done    = clear_done_q;
  assign fb_addr       = fb_addr_q;
  assign fb_wdata      = fb_wdata_q;
  assign fb_we         = fb_we_q;
  assign clipped_count = clipped_q;
  assign overflow      = overflow_q;
endmodule

// File: tb/tb_pixel_sink_fb.sv
// Scoreboard bench for pixel_sink_fb: stimulus queues expected framebuffer
// writes, a negedge monitor retires and compares them.
module tb_pixel_sink_fb;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  x, y;
  logic [2:0]  vga_colour;
  logic        plot;
  logic        ready;
  logic        clear_start;
  logic [2:0]  clear_colour;
  logic        clear_busy, clear_done;
  logic [14:0] fb_addr;
  logic [2:0]  fb_wdata;
  logic        fb_we;
  logic        fb_wait;
  logic [15:0] clipped_count;
  logic        overflow;

  typedef struct packed {
    logic [14:0] addr;
    logic [2:0]  data;
  } wr_t;

  wr_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  exp_clipped = 0;
  bit  mon_en = 1'b0;

  pixel_sink_fb dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .vga_colour(vga_colour), .plot(plot),
    .ready(ready), .clear_start(clear_start), .clear_colour(clear_colour),
    .clear_busy(clear_busy), .clear_done(clear_done), .fb_addr(fb_addr),
    .fb_wdata(fb_wdata), .fb_we(fb_we), .fb_wait(fb_wait),
    .clipped_count(clipped_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference address: plain row-major arithmetic.
  function automatic wr_t mk(input int px, input int py, input int c);
    wr_t w;
    w.addr = 15'(py * 160 + px);
    w.data = 3'(c);
    return w;
  endfunction

  // Drive one pixel for one edge; expectation derived from screen bounds.
  task automatic send(input int px, input int py, input int c);
    x = 8'(px); y = 8'(py); vga_colour = 3'(c); plot = 1'b1;
    if (px < 160 && py < 120) exp_q.push_back(mk(px, py, c));
    else exp_clipped++;
    tick();
    plot = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin tick(); n++; end
    tick(); tick();
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", 32'(ready), 32'd1);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_clear_done", 32'(clear_done), 32'd0);
    chk("rst_clipped", 32'(clipped_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    exp_clipped = 0;
  endtask

  // Monitor: retire writes on fb_we && !fb_wait, check hold under stall.
  logic        prev_stall = 1'b0, prev_rst = 1'b0;
  logic [14:0] prev_addr;
  logic [2:0]  prev_data;
  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_stall && !prev_rst) begin
        chk("hold_we", 32'(fb_we), 32'd1);
        chk("hold_addr", 32'(fb_addr), 32'(prev_addr));
        chk("hold_data", 32'(fb_wdata), 32'(prev_data));
      end
      if (fb_we && !fb_wait) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: addr %0d data %0d, expected no write", fb_addr, fb_wdata);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("wr_addr", 32'(fb_addr), 32'(e.addr));
          chk("wr_data", 32'(fb_wdata), 32'(e.data));
        end
      end
      prev_stall = fb_we && fb_wait;
      prev_addr  = fb_addr;
      prev_data  = fb_wdata;
      prev_rst   = rst;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cycles, done_cnt, n;
    rst = 1'b1; x = '0; y = '0; vga_colour = '0; plot = 1'b0;
    clear_start = 1'b0; clear_colour = '0; fb_wait = 1'b0;
    tick();
    do_reset();
    mon_en = 1'b1;

    // Single pixel latency
    x = 8'd80; y = 8'd60; vga_colour = 3'd7; plot = 1'b1;
    exp_q.push_back(mk(80, 60, 7));
    tick();
    plot = 1'b0;
    tick();
    chk("lat_we", 32'(fb_we), 32'd1);
    chk("lat_addr", 32'(fb_addr), 32'd9680);
    chk("lat_data", 32'(fb_wdata), 32'd7);
    tick();
    chk("lat_we_drop", 32'(fb_we), 32'd0);
    drain("single_drain");

    // Off-screen pixels
    send(160, 0, 1);
    chk("clip_ready1", 32'(ready), 32'd1);
    send(0, 120, 2);
    chk("clip_ready2", 32'(ready), 32'd1);
    tick(); tick();
    chk("clip_count", 32'(clipped_count), 32'd2);
    drain("clip_nowrite");

    // Randomized stream with random memory stalls; plot only offered when ready
    for (int i = 0; i < 400; i++) begin
      fb_wait = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) != 0 && ready) begin
        send(int'($urandom_range(0, 175)), int'($urandom_range(0, 135)), int'($urandom_range(0, 7)));
      end else begin
        tick();
      end
    end
    fb_wait = 1'b0;
    drain("rand_drain");
    chk("rand_clipped", 32'(clipped_count), 32'(exp_clipped));
    chk("rand_overflow", 32'(overflow), 32'd0);

    // Burst of 6 under stall: 4 in FIFO plus 1 in output stage, 6th overflows
    fb_wait = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("burst_ready%0d", i), 32'(ready), (i < 5) ? 32'd1 : 32'd0);
      x = 8'($urandom_range(0, 159)); y = 8'($urandom_range(0, 119));
      vga_colour = 3'($urandom_range(0, 7)); plot = 1'b1;
      if (i < 5) exp_q.push_back(mk(int'(x), int'(y), int'(vga_colour)));
      tick();
    end
    plot = 1'b0;
    chk("burst_overflow", 32'(overflow), 32'd1);
    tick();
    fb_wait = 1'b0;
    drain("burst_drain");

    // Full-screen clear, with a plot arriving mid-sweep
    do_reset();
    for (int i = 0; i < 19200; i++) exp_q.push_back(wr_t'{addr: 15'(i), data: 3'd3});
    clear_colour = 3'd3; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    chk("clr_busy_start", 32'(clear_busy), 32'd1);
    chk("clr_first_addr", 32'(fb_addr), 32'd0);
    chk("clr_first_we", 32'(fb_we), 32'd1);
    busy_cycles = 1; done_cnt = 0;
    for (int c = 0; c < 20100; c++) begin
      if (c == 100) begin
        x = 8'd5; y = 8'd5; vga_colour = 3'd1; plot = 1'b1;
      end else begin
        plot = 1'b0;
      end
      if (!clear_done) chk("clr_ready_low", 32'(ready), 32'd0);
      tick();
      if (clear_done) begin done_cnt++; break; end
      if (clear_busy) busy_cycles++;
    end
    plot = 1'b0;
    chk("clr_done_seen", 32'(done_cnt), 32'd1);
    chk("clr_busy_at_done", 32'(clear_busy), 32'd0);
    chk("clr_cycles", 32'(busy_cycles), 32'd19200);
    tick();
    chk("clr_done_pulse", 32'(clear_done), 32'd0);
    chk("clr_overflow", 32'(overflow), 32'd1);
    drain("clr_drain");

    // clear_start during a 3-pixel drain: pixels retire first, then the sweep
    fb_wait = 1'b1;
    send(1, 2, 4);
    send(159, 119, 6);
    send(7, 0, 2);
    tick();
    for (int i = 0; i < 19200; i++) exp_q.push_back(wr_t'{addr: 15'(i), data: 3'd5});
    clear_colour = 3'd5; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    tick(); tick();
    chk("pend_not_busy", 32'(clear_busy), 32'd0);
    fb_wait = 1'b0;
    n = 0;
    while (!clear_done && n < 20100) begin tick(); n++; end
    chk("pend_done_seen", 32'(clear_done), 32'd1);
    drain("pend_drain");

    // Reset in the middle of a sweep at address 500
    for (int i = 0; i <= 500; i++) exp_q.push_back(wr_t'{addr: 15'(i), data: 3'd2});
    clear_colour = 3'd2; clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (500) tick();
    chk("mid_addr500", 32'(fb_addr), 32'd500);
    rst = 1'b1;
    tick();
    chk("mid_rst_we", 32'(fb_we), 32'd0);
    chk("mid_rst_busy", 32'(clear_busy), 32'd0);
    rst = 1'b0;
    exp_clipped = 0;
    chk("mid_rst_retired", 32'(exp_q.size()), 32'd0);
    send(10, 20, 1);
    drain("post_rst_plot");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pixel_sink_fb.md
# pixel_sink_fb

Consumer end of the drawing-engine pixel stream. Accepts `x`/`y`/`vga_colour`/`plot` pixels from the circle/Reuleaux FSMs, clips anything off the 160×120 screen, and buffers the rest in a small FIFO. Retires buffered pixels as single-pixel writes into the framebuffer RAM. Also provides a full-screen clear sweep, so drawing FSMs never talk to memory directly.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: pixel FIFO entries (power of two, ≥2).
- `SCREEN_W`, 160: visible width in pixels.
- `SCREEN_H`, 120: visible height in pixels.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `x`  in  8  pixel column.
- `y`  in  8  pixel row.
- `vga_colour`  in  3  pixel colour.
- `plot`  in  1  pixel valid; accepted on an edge where `plot && ready`.
- `ready`  out  1  high when the FIFO is not full and state ≠ CLEAR.
- `clear_start`  in  1  single-cycle request to fill the screen with `clear_colour`.
- `clear_colour`  in  3  fill colour, sampled on entry to CLEAR.
- `clear_busy`  out  1  high while in CLEAR.
- `clear_done`  out  1  one-cycle pulse after the last clear write.
- `fb_addr`  out  15  framebuffer address, `y*SCREEN_W + x`.
- `fb_wdata`  out  3  write colour.
- `fb_we`  out  1  write strobe.
- `fb_wait`  in  1  memory stall; while high, `fb_*` outputs hold.
- `clipped_count`  out  16  count of dropped off-screen pixels, saturating at 0xFFFF.
- `overflow`  out  1  sticky; set when `plot` arrives while `ready` is low.

## Operation
- Reset values: `ready`=1, `fb_we`=0, `fb_addr`=0, `fb_wdata`=0, `clear_busy`=0, `clear_done`=0, `clipped_count`=0, `overflow`=0. Reset also sets state to IDLE, empties the FIFO and clears any pending clear request.
- Reset mid-operation (during a drain or a clear): the FIFO is flushed, the sweep is abandoned, and `fb_we` is 0 from the next cycle.
- Clipping:
  - Pixels with `x ≥ SCREEN_W` or `y ≥ SCREEN_H` are consumed (the handshake completes) but never enqueued.
  - Each dropped pixel increments `clipped_count`.
- `ready` is derived from registered occupancy only. A pop in the same cycle does not free a slot for a push when the FIFO is full.
- A `plot` seen while `ready` is low drops that pixel and sets `overflow`. Only `rst` clears `overflow`.
- Address is computed at the FIFO head: `(y<<7)+(y<<5)+x`, 15 bits, no overflow possible after clipping.
- State machine:
  - IDLE: FIFO empty and output stage idle.
    - `clear_start` or a pending clear → CLEAR.
    - FIFO non-empty → DRAIN.
  - DRAIN:
    - Pops the head into the output registers when the output stage is empty or `fb_wait` is low.
    - Returns to IDLE once the FIFO is empty and the last write is retired.
    - A `clear_start` arriving in DRAIN is latched as pending and serviced on return to IDLE.
  - CLEAR:
    - `ready`=0, `clear_busy`=1.
    - Writes addresses 0..19199 (`SCREEN_W*SCREEN_H-1`) with the latched colour, one per non-stalled cycle.
    - After address 19199 is accepted (`fb_wait` low), pulses `clear_done` for one cycle → IDLE.
  - A `clear_start` while already in CLEAR is ignored.

## Timing
- Pixel latency, empty FIFO, no stall: `plot` sampled at edge k → enqueued at k. The head is loaded at edge k+1, and `fb_we`=1 with correct `fb_addr`/`fb_wdata` during cycle k+1..k+2.
- Throughput is 1 pixel/cycle when `fb_wait`=0.
- `fb_wait` semantics: a write is retired on an edge where `fb_we && !fb_wait`. While `fb_wait` is high, `fb_addr`, `fb_wdata` and `fb_we` hold.
- `fb_we` drops the cycle after the last retired write when no further data is available.
- Clear duration with no stall: 19200 write cycles. `clear_done` is asserted on the cycle after the final write; `clear_busy` falls in that same cycle.
- A `clear_start` sampled in IDLE: `clear_busy` is high from the next cycle, and the first write (addr 0) occurs in that cycle.

## Structure
- Package `fb_pkg` holds:
  - `SCREEN_W`, `SCREEN_H`;
  - `FB_ADDR_W`=15, `FB_PIXELS`=19200;
  - enum `fb_state_t` {IDLE, DRAIN, CLEAR};
  - a packed struct `pixel_t` {x, y, colour}.
- One sub-module, `plot_fifo`: a synchronous FIFO of `pixel_t` with push/pop/full/empty/count, parameterised by `FIFO_DEPTH`.
- The top level holds the FSM, the clipping logic, the address arithmetic, the output registers, and the counters.

## Test plan
- Single pixel (80,60,colour 7), `fb_wait`=0 → one `fb_we` pulse, `fb_addr`=9680, `fb_wdata`=7, two edges after the plot.
- Off-screen pixels (160,0) and (0,120) → no `fb_we`, `clipped_count`=2, `ready` stays 1.
- Burst of 6 plots with `fb_wait`=1 held, `FIFO_DEPTH`=4:
  - `ready` falls after 4 enqueued pixels plus 1 held in the output stage;
  - the remaining plot sets `overflow`;
  - releasing `fb_wait` retires 5 writes in order.
- `clear_start` with `clear_colour`=3 → 19200 consecutive writes, addr 0..19199, `clear_done` single pulse, `ready`=0 throughout; a plot during the clear sets `overflow`.
- `clear_start` during a 3-pixel drain → all 3 pixel writes complete first, then the clear begins at addr 0.
- `rst` asserted mid-clear at addr 500 → next cycle `fb_we`=0 and `clear_busy`=0; a subsequent plot is written normally.
